// File: rtl/lsr8_seq_pkg.sv
// lsr8_seq_pkg: shared types and constants for the sequential right shifter.
// Holds the FSM state enum, datapath width, per-cycle step limit and step helper.
package lsr8_seq_pkg;

  localparam int W        = 8;
  localparam int STEP_MAX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [1:0] step_of(
    input logic [2:0] r
  );
    if (r > 3'(STEP_MAX))
      return 2'(STEP_MAX);
    return r[1:0];
  endfunction

endpackage

// File: rtl/lsr8_seq_if.sv
// lsr8_seq_if: start/done request bus of lsr8_seq.
// master drives start/d_in/shamt[/op]; slave returns busy/done/d_out.
interface lsr8_seq_if;
  import lsr8_seq_pkg::*;

  logic         start;
  logic [W-1:0] d_in;
  logic [2:0]   shamt;
`ifdef LSR8_SEQ_ASR_EN
  logic         op;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] d_out;

  modport master (
    output start,
    output d_in,
    output shamt,
`ifdef LSR8_SEQ_ASR_EN
    output op,
`endif
    input  busy,
    input  done,
    input  d_out
  );

  modport slave (
    input  start,
    input  d_in,
    input  shamt,
`ifdef LSR8_SEQ_ASR_EN
    input  op,
`endif
    output busy,
    output done,
    output d_out
  );

endinterface

// File: rtl/lsr8_step.sv
// lsr8_step: combinational 0-3 bit right shift, vacated bits take fill.
// Ports: a (value), sh (step), fill (fill bit), y (shifted value).
module lsr8_step
  import lsr8_seq_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [1:0]   sh,
  input  logic         fill,
  output logic [W-1:0] y
);

  logic [W+STEP_MAX-1:0] ext;

  assign ext = {{STEP_MAX{fill}}, a};

  for (genvar i = 0; i < W; i++) begin : g_mux
    assign y[i] = sh[1]
      ? (sh[0] ? ext[i+3] : ext[i+2])
      : (sh[0] ? ext[i+1] : ext[i]);
  end

endmodule

// File: rtl/lsr8_seq.sv
// lsr8_seq: iterative 8-bit shift right, up to 3 bits per clock.
// Ports: clk, reset (sync, high), bus (slave); LSR8_SEQ_ASR_EN adds op/sign fill.
module lsr8_seq
  import lsr8_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  lsr8_seq_if.slave  bus
);

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] acc_q;
  logic [2:0]   rem_q;
  logic [W-1:0] dout_q;
  logic [1:0]   step;
  logic [W-1:0] shifted;
  logic         fill;
  logic         last;
  logic         accept;

`ifdef LSR8_SEQ_ASR_EN
  logic op_q;
  assign fill = op_q & acc_q[W-1];
`else
  assign fill = 1'b0;
`endif

  assign step   = step_of(rem_q);
  assign last   = rem_q <= 3'(STEP_MAX);
  assign accept = bus.start
    && (state_q == IDLE || state_q == DONE);

  lsr8_step u_step (
    .a    (acc_q),
    .sh   (step),
    .fill (fill),
    .y    (shifted)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE),
      (state_q == DONE): begin
        if (!bus.start)
          state_d = IDLE;
        else if (bus.shamt == 3'd0)
          state_d = DONE;
        else
          state_d = SHIFT;
      end
      (state_q == SHIFT): begin
        if (last)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.d_out = dout_q;
    unique case (1'b1)
      (state_q == SHIFT): bus.busy = 1'b1;
      (state_q == DONE):  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      rem_q  <= '0;
      dout_q <= '0;
`ifdef LSR8_SEQ_ASR_EN
      op_q   <= 1'b0;
`endif
    end else if (accept) begin
      acc_q <= bus.d_in;
      rem_q <= bus.shamt;
`ifdef LSR8_SEQ_ASR_EN
      op_q  <= bus.op;
`endif
      if (bus.shamt == 3'd0)
        dout_q <= bus.d_in;
    end else if (state_q == SHIFT) begin
      acc_q <= shifted;
      rem_q <= rem_q - {1'b0, step};
      if (last)
        dout_q <= shifted;
    end
  end

endmodule
